// File: rtl/sa_autosa_csb_reg_bridge_pkg.sv
// ----------------------------------------------------------------------------
// sa_autosa_csb_pkg
// Shared definitions for the AUTOSA CSB-to-register bridge:
//   - bit positions of the fields inside the CSB request packet
//     {level[1:0], wrbe, srcpriv, nposted, write, wdat, addr}
//     (addr in the LSBs), computed from ADDR_W / DATA_W / BE_W
//   - response type IDs carried in the is_write bit
//   - the bridge FSM state type
// No ports (package).
// ----------------------------------------------------------------------------
package sa_autosa_csb_pkg;

  localparam int REQ_ADDR_LSB = 0;

  function automatic int req_wdat_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int req_write_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int req_nposted_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 1;
  endfunction

  function automatic int req_srcpriv_bit(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

  function automatic int req_wrbe_lsb(input int addr_w, input int data_w);
    return addr_w + data_w + 3;
  endfunction

  function automatic int req_level_lsb(input int addr_w, input int data_w, input int be_w);
    return addr_w + data_w + 3 + be_w;
  endfunction

  function automatic int req_pd_w(input int addr_w, input int data_w, input int be_w);
    return addr_w + data_w + be_w + 5;
  endfunction

  function automatic int resp_pd_w(input int data_w);
    return data_w + 2;
  endfunction

  localparam logic RESP_RD = 1'b0;
  localparam logic RESP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } csb_state_e;

endpackage

// File: rtl/sa_autosa_csb_reg_bridge_if.sv
// ----------------------------------------------------------------------------
// sa_autosa_csb_reg_bridge_if
// CSB request/response channel between the fabric and the bridge.
//   csb2reg_req_pd/pvld/prdy       : request packet with valid/ready
//   reg2csb_resp_pd/valid/prdy     : response packet {is_write, error, rdat}
// Modports:
//   master : fabric side (drives requests, accepts responses)
//   slave  : bridge side (accepts requests, drives responses)
// ----------------------------------------------------------------------------
interface sa_autosa_csb_reg_bridge_if
  import sa_autosa_csb_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);

  localparam int REQ_W  = req_pd_w(ADDR_W, DATA_W, BE_W);
  localparam int RESP_W = resp_pd_w(DATA_W);

  logic [REQ_W-1:0]  csb2reg_req_pd;
  logic              csb2reg_req_pvld;
  logic              csb2reg_req_prdy;
  logic [RESP_W-1:0] reg2csb_resp_pd;
  logic              reg2csb_resp_valid;
  logic              reg2csb_resp_prdy;

  modport master (
    output csb2reg_req_pd,
    output csb2reg_req_pvld,
    input  csb2reg_req_prdy,
    input  reg2csb_resp_pd,
    input  reg2csb_resp_valid,
    output reg2csb_resp_prdy
  );

  modport slave (
    input  csb2reg_req_pd,
    input  csb2reg_req_pvld,
    output csb2reg_req_prdy,
    output reg2csb_resp_pd,
    output reg2csb_resp_valid,
    input  reg2csb_resp_prdy
  );

endinterface

// File: rtl/sa_autosa_csb_req_fifo.sv
// ----------------------------------------------------------------------------
// sa_autosa_csb_req_fifo
// Synchronous request FIFO with simultaneous push/pop.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push, push_data : write side (ignored when not ready)
//   ready       : registered "not full"; low during reset and the cycle after
//   pop, pop_data   : read side, pop_data is the current head (show-ahead)
//   empty       : no entries stored
// ----------------------------------------------------------------------------
module sa_autosa_csb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             ready_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && ready_q;
  assign do_pop   = pop && (count != '0);
  assign empty    = (count == '0);
  assign ready    = ready_q;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Ready is registered from the next occupancy so the request side never
  // sees a combinational path from the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      ready_q <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sa_autosa_csb_reg_bridge.sv
// ----------------------------------------------------------------------------
// sa_autosa_csb_reg_bridge
// CSB slave to generic register-port bridge. Requests are queued in a small
// FIFO, issued one at a time to the register port, range-checked against
// NUM_REGS, and answered with {is_write, error, rdat} responses for reads
// and non-posted writes.
// Ports:
//   autosa_core_clk, autosa_core_rst : clock, synchronous active-high reset
//   csb          : CSB request/response channel (slave modport)
//   reg_offset   : byte offset {addr, 2'b0} of the current request
//   reg_wr_en / reg_wr_data / reg_wr_be : one-cycle write strobe + payload
//   reg_rd_en    : one-cycle read strobe
//   reg_rd_data  : read data, valid RD_LAT cycles after reg_rd_en
// Optional build macro: SA_AUTOSA_CSB_PRIV_CHECK_EN (suppress in-range
// writes with srcpriv = 0 and flag them as errors).
// ----------------------------------------------------------------------------
module sa_autosa_csb_reg_bridge
  import sa_autosa_csb_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int NUM_REGS  = 64,
  parameter int RD_LAT    = 1,
  parameter int REQ_DEPTH = 2
) (
  input  logic                autosa_core_clk,
  input  logic                autosa_core_rst,
  sa_autosa_csb_reg_bridge_if.slave csb,
  output logic [ADDR_W+1:0]   reg_offset,
  output logic                reg_wr_en,
  output logic [DATA_W-1:0]   reg_wr_data,
  output logic [BE_W-1:0]     reg_wr_be,
  output logic                reg_rd_en,
  input  logic [DATA_W-1:0]   reg_rd_data
);

  localparam int REQ_W       = req_pd_w(ADDR_W, DATA_W, BE_W);
  localparam int WDAT_LSB    = req_wdat_lsb(ADDR_W);
  localparam int WRITE_BIT   = req_write_bit(ADDR_W, DATA_W);
  localparam int NPOSTED_BIT = req_nposted_bit(ADDR_W, DATA_W);
  localparam int SRCPRIV_BIT = req_srcpriv_bit(ADDR_W, DATA_W);
  localparam int WRBE_LSB    = req_wrbe_lsb(ADDR_W, DATA_W);
  localparam int LEVEL_LSB   = req_level_lsb(ADDR_W, DATA_W, BE_W);

  localparam logic [ADDR_W:0] NUM_REGS_LIM = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [2:0]      RD_LAT_M1    = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  csb_state_e        state;
  csb_state_e        state_nxt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_ready;
  logic [REQ_W-1:0]  head_pd;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdat;
  logic [BE_W-1:0]   cur_be;
  logic              cur_write;
  logic              cur_nposted;
  logic              cur_srcpriv;

  logic [2:0]        rd_cnt;
  logic              in_range;
  logic              wr_allowed;
  logic              resp_load;
  logic              resp_err_nxt;
  logic              rd_capture;

  logic              resp_is_write;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdat;

  logic              unused_req_bits;

  sa_autosa_csb_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (autosa_core_clk),
    .rst       (autosa_core_rst),
    .push      (fifo_push),
    .push_data (csb.csb2reg_req_pd),
    .ready     (fifo_ready),
    .pop       (fifo_pop),
    .pop_data  (head_pd),
    .empty     (fifo_empty)
  );

  assign fifo_push             = csb.csb2reg_req_pvld && fifo_ready;
  assign csb.csb2reg_req_prdy  = fifo_ready;
  assign csb.reg2csb_resp_pd   = {resp_is_write, resp_err, resp_rdat};
  assign csb.reg2csb_resp_valid = (state == RESP);

  assign in_range    = ({1'b0, cur_addr} < NUM_REGS_LIM);
  assign reg_offset  = {cur_addr, 2'b00};
  assign reg_wr_data = cur_wdat;

  // Privilege gating only exists when the check is built in; otherwise the
  // latched srcpriv bit is carried but has no effect.
`ifdef SA_AUTOSA_CSB_PRIV_CHECK_EN
  assign wr_allowed      = cur_srcpriv;
  assign unused_req_bits = ^head_pd[LEVEL_LSB +: 2];
`else
  assign wr_allowed      = 1'b1;
  assign unused_req_bits = ^{head_pd[LEVEL_LSB +: 2], cur_srcpriv};
`endif

  // State register.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and register-port strobes. Posted writes (in range or not)
  // return to IDLE without a response; everything else goes through RESP.
  always_comb begin
    state_nxt    = state;
    fifo_pop     = 1'b0;
    reg_wr_en    = 1'b0;
    reg_wr_be    = '0;
    reg_rd_en    = 1'b0;
    resp_load    = 1'b0;
    resp_err_nxt = 1'b0;
    rd_capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        resp_load = 1'b1;
        if (!in_range) begin
          resp_err_nxt = 1'b1;
          state_nxt    = (cur_write && !cur_nposted) ? IDLE : RESP;
        end else if (cur_write) begin
          reg_wr_en    = wr_allowed;
          reg_wr_be    = wr_allowed ? cur_be : '0;
          resp_err_nxt = !wr_allowed;
          state_nxt    = cur_nposted ? RESP : IDLE;
        end else begin
          reg_rd_en = 1'b1;
          if (RD_LAT == 0) begin
            rd_capture = 1'b1;
            state_nxt  = RESP;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rd_cnt == 3'd0) begin
          rd_capture = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        if (csb.reg2csb_resp_prdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, read-latency counter and response register. When read
  // data is captured in the same cycle as the response header is loaded
  // (RD_LAT = 0), the later capture assignment wins over the zero default.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      cur_addr      <= '0;
      cur_wdat      <= '0;
      cur_be        <= '0;
      cur_write     <= 1'b0;
      cur_nposted   <= 1'b0;
      cur_srcpriv   <= 1'b0;
      rd_cnt        <= 3'd0;
      resp_is_write <= RESP_RD;
      resp_err      <= 1'b0;
      resp_rdat     <= '0;
    end else begin
      if (fifo_pop) begin
        cur_addr    <= head_pd[REQ_ADDR_LSB +: ADDR_W];
        cur_wdat    <= head_pd[WDAT_LSB +: DATA_W];
        cur_be      <= head_pd[WRBE_LSB +: BE_W];
        cur_write   <= head_pd[WRITE_BIT];
        cur_nposted <= head_pd[NPOSTED_BIT];
        cur_srcpriv <= head_pd[SRCPRIV_BIT];
      end
      if (state == ISSUE) begin
        rd_cnt <= RD_LAT_M1;
      end else if ((state == RD_WAIT) && (rd_cnt != 3'd0)) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
      if (resp_load) begin
        resp_is_write <= cur_write ? RESP_WR : RESP_RD;
        resp_err      <= resp_err_nxt;
        resp_rdat     <= '0;
      end
      if (rd_capture) begin
        resp_rdat <= reg_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sa_autosa_csb_reg_bridge.sv
// ----------------------------------------------------------------------------
// tb_sa_autosa_csb_reg_bridge
// Self-checking bench for sa_autosa_csb_reg_bridge (default parameters,
// RD_LAT = 1, REQ_DEPTH = 2, NUM_REGS = 64). Plays the register bank on the
// register port, drives directed and random CSB traffic, and compares
// responses, strobes and final bank contents with a word-level model.
// Honours SA_AUTOSA_CSB_PRIV_CHECK_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_sa_autosa_csb_reg_bridge;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_REGS  = 64;
  localparam int RD_LAT    = 1;
  localparam int REQ_DEPTH = 2;
  localparam int REQ_W     = ADDR_W + DATA_W + BE_W + 5;

`ifdef SA_AUTOSA_CSB_PRIV_CHECK_EN
  localparam bit PRIV_CHECK = 1'b1;
`else
  localparam bit PRIV_CHECK = 1'b0;
`endif

  logic                autosa_core_clk = 1'b0;
  logic                autosa_core_rst;
  logic [ADDR_W+1:0]   reg_offset;
  logic                reg_wr_en;
  logic [DATA_W-1:0]   reg_wr_data;
  logic [BE_W-1:0]     reg_wr_be;
  logic                reg_rd_en;
  logic [DATA_W-1:0]   reg_rd_data;

  sa_autosa_csb_reg_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  sa_autosa_csb_reg_bridge #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BE_W      (BE_W),
    .NUM_REGS  (NUM_REGS),
    .RD_LAT    (RD_LAT),
    .REQ_DEPTH (REQ_DEPTH)
  ) dut (
    .autosa_core_clk (autosa_core_clk),
    .autosa_core_rst (autosa_core_rst),
    .csb             (bus),
    .reg_offset      (reg_offset),
    .reg_wr_en       (reg_wr_en),
    .reg_wr_data     (reg_wr_data),
    .reg_wr_be       (reg_wr_be),
    .reg_rd_en       (reg_rd_en),
    .reg_rd_data     (reg_rd_data)
  );

  always #5 autosa_core_clk = ~autosa_core_clk;

  int vectors     = 0;
  int miscompares = 0;
  int wr_cnt      = 0;
  int rd_cnt      = 0;
  int valid_cnt   = 0;

  logic [31:0] bank    [NUM_REGS];
  logic [31:0] exp_mem [NUM_REGS];

  function automatic logic [31:0] mergeBytes(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [REQ_W-1:0] mkReq(input int addr, input logic write,
                                             input logic nposted, input logic srcpriv,
                                             input logic [3:0] be, input logic [31:0] wdat,
                                             input logic [1:0] level);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(addr);
    return {level, be, srcpriv, nposted, write, wdat, a};
  endfunction

  // Register bank on the far side of the bridge: read data appears one
  // cycle after the read strobe.
  always @(posedge autosa_core_clk) begin
    int idx;
    idx = int'(reg_offset >> 2);
    if (reg_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (idx < NUM_REGS) bank[idx] <= mergeBytes(bank[idx], reg_wr_data, reg_wr_be);
    end
    if (reg_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      reg_rd_data <= (idx < NUM_REGS) ? bank[idx] : 32'h0BAD_0BAD;
    end
    if (bus.reg2csb_resp_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [REQ_W-1:0] pd);
    int n;
    n = 0;
    bus.csb2reg_req_pd   = pd;
    bus.csb2reg_req_pvld = 1'b1;
    while (bus.csb2reg_req_prdy !== 1'b1 && n < 100) begin
      @(negedge autosa_core_clk);
      n++;
    end
    checkOutput("req_accept", 64'(bus.csb2reg_req_prdy), 64'd1);
    @(negedge autosa_core_clk);
    bus.csb2reg_req_pvld = 1'b0;
  endtask

  task automatic collectResponse(input string tag, input logic [33:0] exp, input int stall);
    int n;
    n = 0;
    bus.reg2csb_resp_prdy = 1'b0;
    while (bus.reg2csb_resp_valid !== 1'b1 && n < 60) begin
      @(negedge autosa_core_clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(bus.reg2csb_resp_valid), 64'd1);
    repeat (stall) @(negedge autosa_core_clk);
    checkOutput({tag, "_pd"}, 64'(bus.reg2csb_resp_pd), 64'(exp));
    bus.reg2csb_resp_prdy = 1'b1;
    @(negedge autosa_core_clk);
    bus.reg2csb_resp_prdy = 1'b0;
    checkOutput({tag, "_drop"}, 64'(bus.reg2csb_resp_valid), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_prdy"},   64'(bus.csb2reg_req_prdy),   64'd0);
    checkOutput({tag, "_valid"},  64'(bus.reg2csb_resp_valid), 64'd0);
    checkOutput({tag, "_pd"},     64'(bus.reg2csb_resp_pd),    64'd0);
    checkOutput({tag, "_wr_en"},  64'(reg_wr_en),              64'd0);
    checkOutput({tag, "_rd_en"},  64'(reg_rd_en),              64'd0);
    checkOutput({tag, "_offset"}, 64'(reg_offset),             64'd0);
    checkOutput({tag, "_wdata"},  64'(reg_wr_data),            64'd0);
    checkOutput({tag, "_be"},     64'(reg_wr_be),              64'd0);
  endtask

  initial begin
    int w0, r0, v0;
    int addr;
    logic write, nposted, srcpriv, in_rng, allowed, has_resp, err;
    logic [3:0]  be;
    logic [31:0] wdat, rdat;

    for (int i = 0; i < NUM_REGS; i++) begin
      bank[i]    = 32'hA500_0000 ^ (i * 32'h0101_0101);
      exp_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    end
    reg_rd_data           = '0;
    bus.csb2reg_req_pd    = '0;
    bus.csb2reg_req_pvld  = 1'b0;
    bus.reg2csb_resp_prdy = 1'b0;
    autosa_core_rst       = 1'b1;
    repeat (3) @(negedge autosa_core_clk);
    checkResetOutputs("reset");
    autosa_core_rst = 1'b0;
    @(negedge autosa_core_clk);
    @(negedge autosa_core_clk);

    // Read with exact latency: strobe at cycle 2, response at cycle 4.
    bank[5] = 32'hDEAD_BEEF;
    exp_mem[5] = 32'hDEAD_BEEF;
    applyStimulus(mkReq(5, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd0));
    @(negedge autosa_core_clk);
    checkOutput("rd5_strobe", 64'(reg_rd_en), 64'd1);
    checkOutput("rd5_offset", 64'(reg_offset), 64'h14);
    @(negedge autosa_core_clk);
    checkOutput("rd5_early_valid", 64'(bus.reg2csb_resp_valid), 64'd0);
    @(negedge autosa_core_clk);
    checkOutput("rd5_cycle4_valid", 64'(bus.reg2csb_resp_valid), 64'd1);
    collectResponse("rd5", {1'b0, 1'b0, 32'hDEAD_BEEF}, 0);

    // Non-posted then posted write to 0x03 with partial byte enables.
    w0 = wr_cnt;
    applyStimulus(mkReq(3, 1'b1, 1'b1, 1'b1, 4'b0101, 32'h1234_5678, 2'd3));
    @(negedge autosa_core_clk);
    checkOutput("wr3_strobe", 64'(reg_wr_en), 64'd1);
    checkOutput("wr3_be", 64'(reg_wr_be), 64'b0101);
    checkOutput("wr3_data", 64'(reg_wr_data), 64'h1234_5678);
    checkOutput("wr3_offset", 64'(reg_offset), 64'h0C);
    exp_mem[3] = mergeBytes(exp_mem[3], 32'h1234_5678, 4'b0101);
    collectResponse("wr3_np", {1'b1, 1'b0, 32'h0}, 1);
    checkOutput("wr3_np_count", 64'(wr_cnt - w0), 64'd1);
    w0 = wr_cnt; v0 = valid_cnt;
    applyStimulus(mkReq(3, 1'b1, 1'b0, 1'b1, 4'b0101, 32'h1234_5678, 2'd0));
    repeat (8) @(negedge autosa_core_clk);
    checkOutput("wr3_posted_noresp", 64'(valid_cnt - v0), 64'd0);
    checkOutput("wr3_posted_count", 64'(wr_cnt - w0), 64'd1);

    // Out-of-range accesses.
    r0 = rd_cnt;
    applyStimulus(mkReq(64, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd0));
    collectResponse("rd40_oor", {1'b0, 1'b1, 32'h0}, 0);
    checkOutput("rd40_no_strobe", 64'(rd_cnt - r0), 64'd0);
    w0 = wr_cnt; v0 = valid_cnt;
    applyStimulus(mkReq(64, 1'b1, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 2'd0));
    repeat (8) @(negedge autosa_core_clk);
    checkOutput("wr40_posted_noresp", 64'(valid_cnt - v0), 64'd0);
    checkOutput("wr40_no_strobe", 64'(wr_cnt - w0), 64'd0);

    // Back-to-back reads with a stalled response channel.
    applyStimulus(mkReq(7, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd1));
    applyStimulus(mkReq(8, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd2));
    applyStimulus(mkReq(9, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd3));
    checkOutput("b2b_full_prdy", 64'(bus.csb2reg_req_prdy), 64'd0);
    repeat (10) @(negedge autosa_core_clk);
    checkOutput("b2b_stall_prdy", 64'(bus.csb2reg_req_prdy), 64'd0);
    checkOutput("b2b_stall_pd", 64'(bus.reg2csb_resp_pd), 64'({2'b00, exp_mem[7]}));
    collectResponse("b2b_0", {1'b0, 1'b0, exp_mem[7]}, 2);
    @(negedge autosa_core_clk);
    checkOutput("b2b_prdy_release", 64'(bus.csb2reg_req_prdy), 64'd1);
    collectResponse("b2b_1", {1'b0, 1'b0, exp_mem[8]}, 0);
    collectResponse("b2b_2", {1'b0, 1'b0, exp_mem[9]}, 3);

    // Reset while a read waits and two more are queued.
    applyStimulus(mkReq(10, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd0));
    applyStimulus(mkReq(11, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd0));
    applyStimulus(mkReq(12, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 2'd0));
    autosa_core_rst = 1'b1;
    @(negedge autosa_core_clk);
    checkResetOutputs("midrst");
    autosa_core_rst = 1'b0;
    r0 = rd_cnt; v0 = valid_cnt;
    repeat (12) @(negedge autosa_core_clk);
    checkOutput("midrst_no_resp", 64'(valid_cnt - v0), 64'd0);
    checkOutput("midrst_no_issue", 64'(rd_cnt - r0), 64'd0);
    checkOutput("midrst_prdy", 64'(bus.csb2reg_req_prdy), 64'd1);

`ifdef SA_AUTOSA_CSB_PRIV_CHECK_EN
    // Unprivileged write is suppressed and flagged; privileged one lands.
    w0 = wr_cnt;
    applyStimulus(mkReq(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hCAFE_F00D, 2'd0));
    collectResponse("priv0", {1'b1, 1'b1, 32'h0}, 0);
    checkOutput("priv0_no_strobe", 64'(wr_cnt - w0), 64'd0);
    w0 = wr_cnt;
    applyStimulus(mkReq(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 2'd0));
    exp_mem[1] = 32'hCAFE_F00D;
    collectResponse("priv1", {1'b1, 1'b0, 32'h0}, 0);
    checkOutput("priv1_strobe", 64'(wr_cnt - w0), 64'd1);
`endif

    // Random traffic against the word-level model.
    for (int t = 0; t < 40; t++) begin
      addr    = int'($urandom_range(0, NUM_REGS + 7));
      write   = 1'($urandom);
      nposted = 1'($urandom);
      srcpriv = 1'($urandom);
      be      = 4'($urandom);
      wdat    = $urandom;
      in_rng  = (addr < NUM_REGS);
      allowed = PRIV_CHECK ? srcpriv : 1'b1;
      has_resp = !write || nposted;
      err     = !in_rng || (write && !allowed);
      rdat    = (!write && in_rng) ? exp_mem[addr] : 32'h0;
      if (write && in_rng && allowed) exp_mem[addr] = mergeBytes(exp_mem[addr], wdat, be);
      w0 = wr_cnt; r0 = rd_cnt; v0 = valid_cnt;
      applyStimulus(mkReq(addr, write, nposted, srcpriv, be, wdat, 2'($urandom)));
      if (has_resp) begin
        collectResponse($sformatf("rnd%0d", t), {write, err, rdat}, int'($urandom_range(0, 3)));
      end else begin
        repeat (6) @(negedge autosa_core_clk);
        checkOutput($sformatf("rnd%0d_noresp", t), 64'(valid_cnt - v0), 64'd0);
      end
      checkOutput($sformatf("rnd%0d_wr", t), 64'(wr_cnt - w0), 64'(write && in_rng && allowed));
      checkOutput($sformatf("rnd%0d_rd", t), 64'(rd_cnt - r0), 64'(!write && in_rng));
      repeat (int'($urandom_range(0, 2))) @(negedge autosa_core_clk);
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      checkOutput($sformatf("bank%0d", i), 64'(bank[i]), 64'(exp_mem[i]));
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
